// File: rtl/elephant_ise_mc_if.sv
// Request/response bundle between the core's XALU slot and the Elephant ISE.
// The core is the master; the ISE is the slave.
interface elephant_ise_mc_if;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [31:0] ise_in1;
  logic [31:0] ise_in2;
  logic        ise_val;
  logic        ise_rdy;
  logic        ise_oval;
  logic        ise_oack;
  logic [31:0] ise_out;

  modport master (
    output ise_fn, ise_imm, ise_in1, ise_in2, ise_val, ise_oack,
    input  ise_rdy, ise_oval, ise_out
  );

  modport slave (
    input  ise_fn, ise_imm, ise_in1, ise_in2, ise_val, ise_oack,
    output ise_rdy, ise_oval, ise_out
  );
endinterface

// File: rtl/elephant_ise_mc.sv
// Multi-cycle Elephant custom-instruction unit: Spongent S-box layer with
// configurable nibbles per cycle, and an iterated round-counter LFSR step.
module elephant_ise_mc #(
  parameter logic [1:0] ISE_V       = 2'b11,
  parameter int         NIB_PER_CYC = 2
) (
  input logic              ise_clk,
  input logic              ise_rst,
  elephant_ise_mc_if.slave ise
);

  localparam int          SPASS   = 8 / NIB_PER_CYC;
  localparam int          SHIFT   = 4 * NIB_PER_CYC;
  localparam logic [3:0]  SPASS_K = 4'(SPASS);
  localparam logic [3:0]  OP_SSTEP  = 4'b0010;
  localparam logic [3:0]  OP_SSTEPX = 4'b0011;
  localparam logic [3:0]  OP_LCNT   = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;  4'h1: sbox = 4'hD;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h2;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h4;  4'h7: sbox = 4'hF;
      4'h8: sbox = 4'h7;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h5;
      4'hC: sbox = 4'h9;  4'hD: sbox = 4'hC;  4'hE: sbox = 4'h3;  default: sbox = 4'h6;
    endcase
  endfunction

  if (ISE_V[1]) begin : g_core
    state_t      state_q, state_d;
    logic [31:0] data_q;
    logic [3:0]  cnt_q;
    logic        lcnt_q;
    logic [3:0]  op;
    logic        op_ok;
    logic        is_lcnt;
    logic        accept;
    logic [3:0]  k_load;
    logic [31:0] sub_word;
    logic [31:0] rot_word;
    logic [31:0] lfsr_next;
    logic        rdy;
    logic        oval;
    logic [31:0] out;

    assign op      = ise.ise_imm[6:3];
    assign is_lcnt = (op == OP_LCNT);
    assign op_ok   = (ise.ise_fn[1:0] == 2'b00) &&
                     ((op == OP_SSTEP) || (op == OP_SSTEPX) || is_lcnt);
    assign accept  = (state_q == IDLE) && ise.ise_val && op_ok;
    assign k_load  = is_lcnt ? ({1'b0, ise.ise_imm[2:0]} + 4'd1) : SPASS_K;

    // Substitute the low nibbles, then rotate right so the next unprocessed
    // nibbles arrive at the bottom; after SPASS passes the word is back in place.
    always_comb begin
      sub_word = data_q;
      for (int i = 0; i < NIB_PER_CYC; i++) begin
        sub_word[4*i +: 4] = sbox(data_q[4*i +: 4]);
      end
      rot_word  = (sub_word >> SHIFT) | (sub_word << (32 - SHIFT));
      lfsr_next = {25'b0, data_q[5:0], data_q[6] ^ data_q[5]};
    end

    always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      rdy     = 1'b0;
      oval    = 1'b0;
      out     = '0;
      case (state_q)
        IDLE: begin
          rdy = 1'b1;
          if (accept) state_d = BUSY;
        end
        BUSY: begin
          if (cnt_q == 4'd1) state_d = DONE;
        end
        DONE: begin
          oval = 1'b1;
          out  = data_q;
          if (ise.ise_oack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
        data_q <= '0;
        cnt_q  <= '0;
        lcnt_q <= 1'b0;
      end else if (accept) begin
        lcnt_q <= is_lcnt;
        cnt_q  <= k_load;
        if (is_lcnt)              data_q <= {25'b0, ise.ise_in1[6:0]};
        else if (op == OP_SSTEPX) data_q <= ise.ise_in1 ^ ise.ise_in2;
        else                      data_q <= ise.ise_in1;
      end else if (state_q == BUSY) begin
        cnt_q  <= cnt_q - 4'd1;
        data_q <= lcnt_q ? lfsr_next : rot_word;
      end
    end

    assign ise.ise_rdy  = rdy;
    assign ise.ise_oval = oval;
    assign ise.ise_out  = out;
  end else begin : g_tieoff
    assign ise.ise_rdy  = 1'b1;
    assign ise.ise_oval = 1'b0;
    assign ise.ise_out  = '0;
  end

endmodule

// File: tb/tb_elephant_ise_mc.sv
// Self-checking bench: N=1, N=2, N=8 and a tied-off instance share stimulus,
// each compared cycle by cycle against a behavioural model.
module tb_elephant_ise_mc;
  localparam int NI  = 4;
  localparam int TIE = 3;
  localparam int TRC = 12;
  localparam logic [3:0] OP_SSTEP  = 4'b0010;
  localparam logic [3:0] OP_SSTEPX = 4'b0011;
  localparam logic [3:0] OP_LCNT   = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  fn_d = '0;
  logic [6:0]  imm_d = '0;
  logic [31:0] in1_d = '0;
  logic [31:0] in2_d = '0;
  logic        val_d = 1'b0;
  logic        oack_d = 1'b0;

  wire [NI-1:0] rdy_w;
  wire [NI-1:0] oval_w;
  wire [31:0]   out_w [NI];

  int          checks = 0;
  int          errors = 0;
  int          lat_m [NI];
  logic [31:0] res_m [NI];
  logic [33:0] trc [NI][TRC+1];
  logic [3:0]  sbox_m [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                              4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  always #5 clk = ~clk;

  elephant_ise_mc_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int         N = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam logic [1:0] V = (g == TIE) ? 2'b00 : 2'b11;
    assign bus[g].ise_fn   = fn_d;
    assign bus[g].ise_imm  = imm_d;
    assign bus[g].ise_in1  = in1_d;
    assign bus[g].ise_in2  = in2_d;
    assign bus[g].ise_val  = val_d;
    assign bus[g].ise_oack = oack_d;
    assign rdy_w[g]  = bus[g].ise_rdy;
    assign oval_w[g] = bus[g].ise_oval;
    assign out_w[g]  = bus[g].ise_out;
    elephant_ise_mc #(.ISE_V(V), .NIB_PER_CYC(N)) dut (
      .ise_clk (clk),
      .ise_rst (rst_n),
      .ise     (bus[g])
    );
  end

  function automatic int nib_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 8;
  endfunction

  function automatic logic [31:0] m_sstep(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = sbox_m[x[4*i +: 4]];
    return r;
  endfunction

  // Counter update written as arithmetic: shift left in 7 bits, new bit 0 = b6 xor b5.
  function automatic logic [31:0] m_lcnt(input int s, input int k);
    int v;
    v = s % 128;
    for (int j = 0; j < k; j++) v = ((v * 2) % 128) + (((v / 64) + ((v / 32) % 2)) % 2);
    return 32'(v);
  endfunction

  task automatic set_model_sbox(input logic [31:0] x);
    for (int i = 0; i < NI; i++) begin
      lat_m[i] = 8 / nib_of(i) + 1;
      res_m[i] = m_sstep(x);
    end
  endtask

  task automatic set_model_lcnt(input logic [31:0] a, input logic [2:0] k);
    for (int i = 0; i < NI; i++) begin
      lat_m[i] = int'(k) + 2;
      res_m[i] = m_lcnt(int'(a[6:0]), int'(k) + 1);
    end
  endtask

  // Issue one request with ack held high, scramble inputs after accept, record outputs.
  task automatic issue_op(input logic [5:0] fn, input logic [6:0] imm,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    fn_d = fn; imm_d = imm; in1_d = a; in2_d = b; val_d = 1'b1; oack_d = 1'b1;
    @(posedge clk);
    #1;
    val_d = 1'b0; fn_d = 6'($urandom); imm_d = 7'($urandom);
    in1_d = $urandom; in2_d = $urandom;
    for (int c = 1; c <= TRC; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) trc[i][c] = {rdy_w[i], oval_w[i], out_w[i]};
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_hold inst%0d got rdy/oval/out=%h want %h", i,
                 {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_release inst%0d got %h want %h", i,
                 {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
      end
    end
  endtask

  task automatic test_sstep();
    logic [31:0] vec [3] = '{32'h01234567, 32'h89ABCDEF, 32'h00000000};
    logic [31:0] a;
    logic [33:0] exp;
    for (int t = 0; t < 7; t++) begin
      a = (t < 3) ? vec[t] : $urandom;
      set_model_sbox(a);
      issue_op(6'($urandom_range(0, 15) * 4), {OP_SSTEP, 3'($urandom_range(0, 7))}, a, $urandom);
      for (int i = 0; i < NI; i++) begin
        for (int c = 1; c <= TRC; c++) begin
          if (i == TIE)          exp = {2'b10, 32'h0};
          else if (c == lat_m[i]) exp = {2'b01, res_m[i]};
          else                   exp = {(c > lat_m[i]), 1'b0, 32'h0};
          checks++;
          if (trc[i][c] !== exp) begin
            errors++;
            $display("[TB] FAIL sstep rs1=%h inst%0d cyc%0d got %h want %h", a, i, c, trc[i][c], exp);
          end
        end
      end
    end
  endtask

  task automatic test_sstepx();
    logic [31:0] va [2] = '{32'hFFFFFFFF, 32'h0000000F};
    logic [31:0] vb [2] = '{32'hFFFFFFFF, 32'h00000000};
    logic [31:0] a, b;
    logic [33:0] exp;
    for (int t = 0; t < 5; t++) begin
      a = (t < 2) ? va[t] : $urandom;
      b = (t < 2) ? vb[t] : $urandom;
      set_model_sbox(a ^ b);
      issue_op(6'h00, {OP_SSTEPX, 3'b000}, a, b);
      for (int i = 0; i < NI; i++) begin
        for (int c = 1; c <= TRC; c++) begin
          if (i == TIE)          exp = {2'b10, 32'h0};
          else if (c == lat_m[i]) exp = {2'b01, res_m[i]};
          else                   exp = {(c > lat_m[i]), 1'b0, 32'h0};
          checks++;
          if (trc[i][c] !== exp) begin
            errors++;
            $display("[TB] FAIL sstepx a=%h b=%h inst%0d cyc%0d got %h want %h", a, b, i, c, trc[i][c], exp);
          end
        end
      end
    end
  endtask

  task automatic test_lcnt();
    logic [31:0] va [3] = '{32'h00000075, 32'h00000075, 32'hFFFFFF80};
    logic [2:0]  vk [3] = '{3'd0, 3'd1, 3'd7};
    logic [31:0] a;
    logic [2:0]  k;
    logic [33:0] exp;
    for (int t = 0; t < 8; t++) begin
      a = (t < 3) ? va[t] : $urandom;
      k = (t < 3) ? vk[t] : 3'($urandom_range(0, 7));
      set_model_lcnt(a, k);
      issue_op(6'($urandom_range(0, 15) * 4), {OP_LCNT, k}, a, $urandom);
      for (int i = 0; i < NI; i++) begin
        for (int c = 1; c <= TRC; c++) begin
          if (i == TIE)          exp = {2'b10, 32'h0};
          else if (c == lat_m[i]) exp = {2'b01, res_m[i]};
          else                   exp = {(c > lat_m[i]), 1'b0, 32'h0};
          checks++;
          if (trc[i][c] !== exp) begin
            errors++;
            $display("[TB] FAIL lcnt rs1=%h imm=%0d inst%0d cyc%0d got %h want %h", a, k, i, c, trc[i][c], exp);
          end
        end
      end
    end
  endtask

  task automatic test_unsupported();
    logic [5:0] fns  [4] = '{6'h00, 6'h01, 6'h02, 6'h00};
    logic [6:0] imms [4] = '{7'b0111000, {OP_SSTEP, 3'b0}, {OP_LCNT, 3'b1}, 7'b0000101};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      fn_d = fns[t]; imm_d = imms[t]; in1_d = $urandom; in2_d = $urandom;
      val_d = 1'b1; oack_d = 1'($urandom);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          checks++;
          if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL unsupported fn=%h imm=%b inst%0d got %h want %h", fns[t], imms[t], i,
                     {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
          end
        end
      end
    end
    val_d = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b2;
    logic [2:0]  k2;
    logic [33:0] exp;
    a = $urandom;
    @(negedge clk);
    fn_d = 6'h00; imm_d = {OP_SSTEP, 3'b0}; in1_d = a; val_d = 1'b1; oack_d = 1'b0;
    @(posedge clk);
    #1 val_d = 1'b0;
    repeat (10) @(negedge clk);
    b2 = $urandom; k2 = 3'($urandom_range(0, 7));
    fn_d = 6'h00; imm_d = {OP_LCNT, k2}; in1_d = b2; val_d = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        exp = (i == TIE) ? {2'b10, 32'h0} : {2'b01, m_sstep(a)};
        checks++;
        if ({rdy_w[i], oval_w[i], out_w[i]} !== exp) begin
          errors++;
          $display("[TB] FAIL backpressure_hold inst%0d cyc%0d got %h want %h", i, c,
                   {rdy_w[i], oval_w[i], out_w[i]}, exp);
        end
      end
    end
    oack_d = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
        errors++;
        $display("[TB] FAIL backpressure_after_ack inst%0d got %h want %h", i,
                 {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
      end
    end
    set_model_lcnt(b2, k2);
    @(posedge clk);
    #1 val_d = 1'b0; in1_d = $urandom; imm_d = 7'($urandom);
    for (int c = 1; c <= TRC; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (i == TIE)          exp = {2'b10, 32'h0};
        else if (c == lat_m[i]) exp = {2'b01, res_m[i]};
        else                   exp = {(c > lat_m[i]), 1'b0, 32'h0};
        checks++;
        if ({rdy_w[i], oval_w[i], out_w[i]} !== exp) begin
          errors++;
          $display("[TB] FAIL backpressure_second inst%0d cyc%0d got %h want %h", i, c,
                   {rdy_w[i], oval_w[i], out_w[i]}, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] a;
    logic [2:0]  k;
    logic [33:0] exp;
    @(negedge clk);
    fn_d = 6'h00; imm_d = {OP_SSTEP, 3'b0}; in1_d = $urandom; val_d = 1'b1; oack_d = 1'b1;
    @(posedge clk);
    #1 val_d = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_mid_op inst%0d got %h want %h", i,
                 {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < TRC; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({rdy_w[i], oval_w[i], out_w[i]} !== {2'b10, 32'h0}) begin
          errors++;
          $display("[TB] FAIL reset_discard inst%0d cyc%0d got %h want %h", i, c,
                   {rdy_w[i], oval_w[i], out_w[i]}, {2'b10, 32'h0});
        end
      end
    end
    a = $urandom; k = 3'($urandom_range(0, 7));
    set_model_lcnt(a, k);
    issue_op(6'h00, {OP_LCNT, k}, a, $urandom);
    for (int i = 0; i < NI; i++) begin
      for (int c = 1; c <= TRC; c++) begin
        if (i == TIE)          exp = {2'b10, 32'h0};
        else if (c == lat_m[i]) exp = {2'b01, res_m[i]};
        else                   exp = {(c > lat_m[i]), 1'b0, 32'h0};
        checks++;
        if (trc[i][c] !== exp) begin
          errors++;
          $display("[TB] FAIL reset_then_lcnt inst%0d cyc%0d got %h want %h", i, c, trc[i][c], exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sstep();
    test_sstepx();
    test_lcnt();
    test_unsupported();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
